// File: rtl/dot_prod_cfg.sv
// dot_prod_cfg: streaming complex dot product with configurable frame length.
//
// Each accepted x/y sample pair is multiplied (optionally against conj(y)),
// the products of one frame are summed, and the frame total is presented,
// saturated to out_bits, on an AXI-stream style output.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   m_axis_x_tvalid, xi, xq  x sample (signed) and its valid
//   m_axis_y_tvalid, yi, yq  y sample (signed) and its valid
//   xy_tready                high when a sample pair can be accepted
//   len, conj                frame length and conjugate select, taken at frame start
//   m_axis_product_tready    downstream accepts the result
//   s_axis_product_tvalid    result valid
//   i, q, sat                saturated result and clamp flag
module dot_prod_cfg #(
    parameter int x_bits     = 12,
    parameter int y_bits     = 12,
    parameter int max_length = 16,
    parameter int len_bits   = 5,
    parameter int out_bits   = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m_axis_x_tvalid,
    input  logic [x_bits-1:0]   xi,
    input  logic [x_bits-1:0]   xq,
    input  logic                m_axis_y_tvalid,
    input  logic [y_bits-1:0]   yi,
    input  logic [y_bits-1:0]   yq,
    output logic                xy_tready,
    input  logic [len_bits-1:0] len,
    input  logic                conj,
    input  logic                m_axis_product_tready,
    output logic                s_axis_product_tvalid,
    output logic [out_bits-1:0] i,
    output logic [out_bits-1:0] q,
    output logic                sat
);

    localparam int prod_bits = x_bits + y_bits + 1;
    localparam int acc_bits  = prod_bits + $clog2(max_length);
    localparam logic [len_bits-1:0] max_len_c = len_bits'(max_length);

    logic                       en;
    logic                       accept;
    logic                       frame_start;
    logic                       last;
    logic [len_bits-1:0]        cnt;
    logic [len_bits-1:0]        lat_len;
    logic                       lat_conj;
    logic [len_bits-1:0]        new_len;
    logic [len_bits-1:0]        eff_len;
    logic                       eff_conj;

    logic                       s1_valid, s1_last, s1_first, s1_conj;
    logic signed [x_bits-1:0]   s1_xi, s1_xq;
    logic signed [y_bits-1:0]   s1_yi, s1_yq;

    logic signed [prod_bits-1:0] xi_e, xq_e, yi_e, yq_e;
    logic signed [prod_bits-1:0] rr, ii, ri, ir;
    logic signed [prod_bits-1:0] mult_i, mult_q;

    logic                       p_valid, p_last, p_first;
    logic signed [prod_bits-1:0] p_i, p_q;

    logic signed [acc_bits-1:0] acc_i, acc_q;
    logic signed [acc_bits-1:0] sum_i, sum_q;
    logic [out_bits-1:0]        res_i, res_q;
    logic                       res_sat;

    // The whole pipeline freezes only while a finished result waits for the consumer.
    assign en        = !(s_axis_product_tvalid && !m_axis_product_tready);
    assign xy_tready = en;
    assign accept    = m_axis_x_tvalid && m_axis_y_tvalid && en;

    // Frame length and conjugate come from the inputs at the first sample of a
    // frame and from the latched copies for the rest of it.
    always_comb begin
        new_len = len;
        if (len == '0)
            new_len = len_bits'(1);
        else if (len > max_len_c)
            new_len = max_len_c;
        frame_start = (cnt == '0);
        eff_len     = frame_start ? new_len : lat_len;
        eff_conj    = frame_start ? conj : lat_conj;
        last        = (cnt == eff_len - len_bits'(1));
    end

    // Sample counter; wraps to 0 after the last sample so the next frame starts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            lat_len  <= '0;
            lat_conj <= 1'b0;
        end else if (accept) begin
            if (frame_start) begin
                lat_len  <= new_len;
                lat_conj <= conj;
            end
            cnt <= last ? '0 : cnt + len_bits'(1);
        end
    end

    // Input capture stage: holds the accepted sample with its frame tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_first <= 1'b0;
            s1_conj  <= 1'b0;
            s1_xi    <= '0;
            s1_xq    <= '0;
            s1_yi    <= '0;
            s1_yq    <= '0;
        end else if (en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_last  <= last;
                s1_first <= frame_start;
                s1_conj  <= eff_conj;
                s1_xi    <= $signed(xi);
                s1_xq    <= $signed(xq);
                s1_yi    <= $signed(yi);
                s1_yq    <= $signed(yq);
            end
        end
    end

    // Operands are widened first so every partial product and sum is exact.
    always_comb begin
        xi_e   = prod_bits'(s1_xi);
        xq_e   = prod_bits'(s1_xq);
        yi_e   = prod_bits'(s1_yi);
        yq_e   = prod_bits'(s1_yq);
        rr     = xi_e * yi_e;
        ii     = xq_e * yq_e;
        ri     = xi_e * yq_e;
        ir     = xq_e * yi_e;
        mult_i = s1_conj ? (rr + ii) : (rr - ii);
        mult_q = s1_conj ? (ir - ri) : (ri + ir);
    end

    // Multiply stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            p_first <= 1'b0;
            p_i     <= '0;
            p_q     <= '0;
        end else if (en) begin
            p_valid <= s1_valid;
            if (s1_valid) begin
                p_last  <= s1_last;
                p_first <= s1_first;
                p_i     <= mult_i;
                p_q     <= mult_q;
            end
        end
    end

    // First product of a frame replaces the accumulator instead of adding to it,
    // so consecutive frames need no clearing cycle.
    always_comb begin
        sum_i = (p_first ? '0 : acc_i) + acc_bits'(p_i);
        sum_q = (p_first ? '0 : acc_q) + acc_bits'(p_q);
    end

    generate
        if (out_bits < acc_bits) begin : g_clamp
            localparam logic signed [acc_bits-1:0] max_v =
                {{(acc_bits-out_bits+1){1'b0}}, {(out_bits-1){1'b1}}};
            localparam logic signed [acc_bits-1:0] min_v = ~max_v;
            logic hi_i, lo_i, hi_q, lo_q;
            assign hi_i    = sum_i > max_v;
            assign lo_i    = sum_i < min_v;
            assign hi_q    = sum_q > max_v;
            assign lo_q    = sum_q < min_v;
            assign res_i   = hi_i ? max_v[out_bits-1:0] : (lo_i ? min_v[out_bits-1:0] : sum_i[out_bits-1:0]);
            assign res_q   = hi_q ? max_v[out_bits-1:0] : (lo_q ? min_v[out_bits-1:0] : sum_q[out_bits-1:0]);
            assign res_sat = hi_i || lo_i || hi_q || lo_q;
        end else begin : g_extend
            assign res_i   = {{(out_bits-acc_bits+1){sum_i[acc_bits-1]}}, sum_i[acc_bits-2:0]};
            assign res_q   = {{(out_bits-acc_bits+1){sum_q[acc_bits-1]}}, sum_q[acc_bits-2:0]};
            assign res_sat = 1'b0;
        end
    endgenerate

    // Accumulate and output stage. When en is high with a result showing, the
    // consumer is taking it, so valid drops unless a new total lands now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_i                 <= '0;
            acc_q                 <= '0;
            s_axis_product_tvalid <= 1'b0;
            i                     <= '0;
            q                     <= '0;
            sat                   <= 1'b0;
        end else if (en) begin
            if (p_valid && p_last) begin
                i                     <= res_i;
                q                     <= res_q;
                sat                   <= res_sat;
                s_axis_product_tvalid <= 1'b1;
            end else begin
                s_axis_product_tvalid <= 1'b0;
                if (p_valid) begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_prod_cfg.sv
// tb_dot_prod_cfg: scoreboard bench for dot_prod_cfg. Two instances share the
// stimulus: one with the default 24-bit output and one with a 12-bit output so
// that saturation is exercised on both widths from the same frame totals.
module tb_dot_prod_cfg;

    localparam int max_l = 16;

    logic        clk;
    logic        rst_n;
    logic        m_axis_x_tvalid;
    logic [11:0] xi, xq;
    logic        m_axis_y_tvalid;
    logic [11:0] yi, yq;
    logic [4:0]  len;
    logic        conj;
    logic        m_axis_product_tready;

    logic        xy_tready, s_axis_product_tvalid, sat;
    logic [23:0] i, q;
    logic        xy_tready_s, valid_s, sat_s;
    logic [11:0] i_s, q_s;

    typedef struct {
        longint si;
        longint sq;
    } exp_t;

    exp_t   exp_q[$];
    int     tests_run;
    int     tests_failed;

    int     m_cnt;
    int     m_len;
    bit     m_conj;
    longint m_si, m_sq;

    bit          held;
    logic [23:0] held_i, held_q;
    logic        held_sat;

    dot_prod_cfg dut (
        .clk(clk), .rst_n(rst_n),
        .m_axis_x_tvalid(m_axis_x_tvalid), .xi(xi), .xq(xq),
        .m_axis_y_tvalid(m_axis_y_tvalid), .yi(yi), .yq(yq),
        .xy_tready(xy_tready), .len(len), .conj(conj),
        .m_axis_product_tready(m_axis_product_tready),
        .s_axis_product_tvalid(s_axis_product_tvalid),
        .i(i), .q(q), .sat(sat)
    );

    dot_prod_cfg #(.out_bits(12)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .m_axis_x_tvalid(m_axis_x_tvalid), .xi(xi), .xq(xq),
        .m_axis_y_tvalid(m_axis_y_tvalid), .yi(yi), .yq(yq),
        .xy_tready(xy_tready_s), .len(len), .conj(conj),
        .m_axis_product_tready(m_axis_product_tready),
        .s_axis_product_tvalid(valid_s),
        .i(i_s), .q(q_s), .sat(sat_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic longint clamp(input longint v, input int bits);
        longint mx = (longint'(1) <<< (bits - 1)) - 1;
        longint mn = -mx - 1;
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    // Reference model: a frame is just a list of complex products added up.
    task automatic modelAccept(input logic [11:0] a_xi, a_xq, a_yi, a_yq,
                               input logic [4:0] a_len, input bit a_conj);
        longint xr = longint'($signed(a_xi));
        longint xm = longint'($signed(a_xq));
        longint yr = longint'($signed(a_yi));
        longint ym = longint'($signed(a_yq));
        longint pi, pq;
        exp_t   e;
        if (m_cnt == 0) begin
            m_len  = (a_len == 0) ? 1 : ((int'(a_len) > max_l) ? max_l : int'(a_len));
            m_conj = a_conj;
            m_si   = 0;
            m_sq   = 0;
        end
        if (m_conj) begin
            pi = xr * yr + xm * ym;
            pq = xm * yr - xr * ym;
        end else begin
            pi = xr * yr - xm * ym;
            pq = xr * ym + xm * yr;
        end
        m_si += pi;
        m_sq += pq;
        m_cnt++;
        if (m_cnt == m_len) begin
            e.si = m_si;
            e.sq = m_sq;
            exp_q.push_back(e);
            m_cnt = 0;
        end
    endtask

    // Drives one cycle of inputs at the falling edge and books the sample in
    // the model if it will be accepted at the next rising edge.
    task automatic applyStimulus(input bit xv, input bit yv,
                                 input logic [11:0] a_xi, a_xq, a_yi, a_yq,
                                 input logic [4:0] a_len, input bit a_conj, input bit a_ready);
        @(negedge clk);
        m_axis_x_tvalid       = xv;
        m_axis_y_tvalid       = yv;
        xi                    = a_xi;
        xq                    = a_xq;
        yi                    = a_yi;
        yq                    = a_yq;
        len                   = a_len;
        conj                  = a_conj;
        m_axis_product_tready = a_ready;
        #1;
        if (rst_n && xv && yv && xy_tready)
            modelAccept(a_xi, a_xq, a_yi, a_yq, a_len, a_conj);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 12'd0, 5'd0, 1'b0, 1'b1);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n           = 1'b0;
        m_axis_x_tvalid = 1'b0;
        m_axis_y_tvalid = 1'b0;
        m_cnt           = 0;
        exp_q.delete();
        #1;
        checkOutput("rst_valid", longint'(s_axis_product_tvalid), 0);
        checkOutput("rst_i", longint'(i), 0);
        checkOutput("rst_q", longint'(q), 0);
        checkOutput("rst_sat", longint'(sat), 0);
        checkOutput("rst_tready", longint'(xy_tready), 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            idleCycle();
            n++;
        end
        idleCycle();
        idleCycle();
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
        end
    endtask

    // Monitor: samples mid-cycle, checks results on each handshake and checks
    // that a stalled result stays put.
    always begin
        exp_t e;
        @(negedge clk);
        #3;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checkOutput("hold_valid", longint'(s_axis_product_tvalid), 1);
                checkOutput("hold_i", longint'(i), longint'(held_i));
                checkOutput("hold_q", longint'(q), longint'(held_q));
                checkOutput("hold_sat", longint'(sat), longint'(held_sat));
            end
            if (s_axis_product_tvalid) begin
                if (m_axis_product_tready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL unexpected_output: got i=%0d q=%0d expected no result",
                                 $signed(i), $signed(q));
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("i", longint'($signed(i)), clamp(e.si, 24));
                        checkOutput("q", longint'($signed(q)), clamp(e.sq, 24));
                        checkOutput("sat", longint'(sat),
                                    longint'(clamp(e.si, 24) != e.si || clamp(e.sq, 24) != e.sq));
                        checkOutput("valid_12", longint'(valid_s), 1);
                        checkOutput("i_12", longint'($signed(i_s)), clamp(e.si, 12));
                        checkOutput("q_12", longint'($signed(q_s)), clamp(e.sq, 12));
                        checkOutput("sat_12", longint'(sat_s),
                                    longint'(clamp(e.si, 12) != e.si || clamp(e.sq, 12) != e.sq));
                    end
                end else begin
                    held     = 1'b1;
                    held_i   = i;
                    held_q   = q;
                    held_sat = sat;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        logic [11:0] r0, r1, r2, r3;
        tests_run             = 0;
        tests_failed          = 0;
        held                  = 1'b0;
        m_cnt                 = 0;
        rst_n                 = 1'b0;
        m_axis_x_tvalid       = 1'b0;
        m_axis_y_tvalid       = 1'b0;
        xi                    = '0;
        xq                    = '0;
        yi                    = '0;
        yq                    = '0;
        len                   = '0;
        conj                  = 1'b0;
        m_axis_product_tready = 1'b1;
        #12;
        doReset();

        // len=4 frame, no conjugate, then check the two-edge latency.
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 1'b1, 12'd1, 12'd1, 12'd2, 12'd3, 5'd4, 1'b0, 1'b1);
        idleCycle();
        idleCycle();
        checkOutput("latency_early", longint'(s_axis_product_tvalid), 0);
        idleCycle();
        checkOutput("latency_k2", longint'(s_axis_product_tvalid), 1);
        checkOutput("latency_i", longint'($signed(i)), -4);
        checkOutput("latency_q", longint'($signed(q)), 20);
        drain();

        // Same frame with conjugate; len/conj changes mid-frame must be ignored.
        applyStimulus(1'b1, 1'b1, 12'd1, 12'd1, 12'd2, 12'd3, 5'd4, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, 1'b1, 12'd1, 12'd1, 12'd2, 12'd3, 5'd2, 1'b0, 1'b1);
        drain();

        // len=0 means single-sample frames, one result per cycle.
        for (int k = 0; k < 6; k++)
            applyStimulus(1'b1, 1'b1, 12'd5, 12'd0, 12'd3, 12'd0, 5'd0, 1'b0, 1'b1);
        drain();

        // Backpressure: consumer stalls, block must stop accepting and lose nothing.
        for (int k = 0; k < 8; k++) begin
            r0 = 12'($urandom_range(0, 4095));
            r1 = 12'($urandom_range(0, 4095));
            r2 = 12'($urandom_range(0, 4095));
            r3 = 12'($urandom_range(0, 4095));
            applyStimulus(1'b1, 1'b1, r0, r1, r2, r3, 5'd3, 1'b0, 1'b0);
        end
        checkOutput("stall_tready", longint'(xy_tready), 0);
        for (int k = 0; k < 4; k++) begin
            r0 = 12'($urandom_range(0, 4095));
            r1 = 12'($urandom_range(0, 4095));
            r2 = 12'($urandom_range(0, 4095));
            r3 = 12'($urandom_range(0, 4095));
            applyStimulus(1'b1, 1'b1, r0, r1, r2, r3, 5'd3, 1'b0, k == 0);
        end
        for (int k = 0; k < 6; k++) begin
            r0 = 12'($urandom_range(0, 4095));
            r1 = 12'($urandom_range(0, 4095));
            r2 = 12'($urandom_range(0, 4095));
            r3 = 12'($urandom_range(0, 4095));
            applyStimulus(1'b1, 1'b1, r0, r1, r2, r3, 5'd3, 1'b0, 1'b1);
        end
        drain();
        doReset();

        // Positive and negative saturation at full length, and len above max_length.
        for (int k = 0; k < 16; k++)
            applyStimulus(1'b1, 1'b1, 12'd2047, 12'd0, 12'd2047, 12'd0, 5'd16, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++)
            applyStimulus(1'b1, 1'b1, 12'h800, 12'd0, 12'd2047, 12'd0, 5'd16, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++)
            applyStimulus(1'b1, 1'b1, 12'd1, 12'd0, 12'd1, 12'd0, 5'd31, 1'b0, 1'b1);
        drain();

        // Reset mid-frame discards the partial sum.
        for (int k = 0; k < 2; k++)
            applyStimulus(1'b1, 1'b1, 12'd100, 12'd7, 12'd9, 12'd3, 5'd4, 1'b0, 1'b1);
        doReset();
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 1'b1, 12'd1, 12'd0, 12'd1, 12'd0, 5'd4, 1'b0, 1'b1);
        drain();

        // Randomized traffic: gaps on either input, random backpressure, random len/conj.
        for (int k = 0; k < 600; k++) begin
            r0 = 12'($urandom_range(0, 4095));
            r1 = 12'($urandom_range(0, 4095));
            r2 = 12'($urandom_range(0, 4095));
            r3 = 12'($urandom_range(0, 4095));
            applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 9,
                          r0, r1, r2, r3, 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
